// File: rtl/mc_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_core_pkg
// Purpose  : Opcode/state encodings and instruction field positions for mc_core.
// Revision : 1.0
// ============================================================================
package mc_core_pkg;

  typedef enum logic [2:0] {
    OP_MOV  = 3'b000,
    OP_ADD  = 3'b001,
    OP_XOR  = 3'b010,
    OP_LDI  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_HALT = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_LOAD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] REG_OUT = 3'd7;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int B_HI  = 5;
  localparam int B_LO  = 3;
  localparam int A_HI  = 2;
  localparam int A_LO  = 0;

endpackage
`default_nettype wire

// File: rtl/mc_core_regfile.sv
`default_nettype none
// ============================================================================
// Module   : mc_core_regfile
// Purpose  : 8 x W register file, two async read ports, one sync write port.
// Revision : 1.0
// ============================================================================
module mc_core_regfile
  import mc_core_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         we,
  input  logic [2:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [2:0]   raddr_a,
  input  logic [2:0]   raddr_b,
  output logic [W-1:0] rdata_a,
  output logic [W-1:0] rdata_b,
  output logic [W-1:0] out_reg
);

  logic [W-1:0] regs [8];

  // Start-of-program clear takes priority over any pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign out_reg = regs[REG_OUT];

endmodule
`default_nettype wire

// File: rtl/mc_core.sv
`default_nettype none
// ============================================================================
// Module   : mc_core
// Purpose  : Multi-cycle 9-bit-instruction core; MC_CORE_CYCLE_CNT_EN adds cycle_cnt.
// Revision : 1.0
// ============================================================================
module mc_core
  import mc_core_pkg::*;
#(
  parameter int W      = 8,
  parameter int D      = 12,
  parameter int END_PC = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req,
  output logic         done,
  output logic [D-1:0] imem_addr,
  input  logic [8:0]   imem_data,
  output logic [W-1:0] dmem_addr,
  output logic [W-1:0] dmem_wdata,
  output logic         dmem_we,
  input  logic [W-1:0] dmem_rdata
`ifdef MC_CORE_CYCLE_CNT_EN
  ,
  output logic [31:0]  cycle_cnt
`endif
);

  localparam logic [D-1:0] PC_ONE   = {{(D-1){1'b0}}, 1'b1};
  localparam logic [31:0]  END_PC_U = 32'(END_PC);

  state_e       state;
  logic [D-1:0] pc;
  logic [8:0]   ir;
  logic [8:0]   instr;
  op_e          op;
  logic [2:0]   fa;
  logic [2:0]   fb;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [W-1:0] r7;
  logic [W-1:0] imm;
  logic [D-1:0] br_off;
  logic [D-1:0] pc_next;
  logic         end_hit;
  logic         rf_clr;
  logic         rf_we;
  logic [2:0]   rf_waddr;
  logic [W-1:0] rf_wdata;

  // EXEC decodes straight from the ROM output; LOAD reuses the latched copy.
  assign instr = (state == S_EXEC) ? imem_data : ir;
  assign op    = op_e'(instr[OP_HI:OP_LO]);
  assign fa    = instr[A_HI:A_LO];
  assign fb    = instr[B_HI:B_LO];
  assign imm   = {{(W-6){1'b0}}, instr[B_HI:A_LO]};

  generate
    if (W >= D) begin : g_off_trunc
      assign br_off = r7[D-1:0];
    end else begin : g_off_sext
      assign br_off = {{(D-W){r7[W-1]}}, r7};
    end
  endgenerate

  assign pc_next = (op == OP_BEQ && ra == rb) ? pc + br_off : pc + PC_ONE;
  assign end_hit = (32'(pc_next) == END_PC_U);

  assign imem_addr  = pc;
  assign dmem_addr  = ra;
  assign dmem_wdata = rb;
  assign dmem_we    = (state == S_EXEC) && (op == OP_ST);
  assign rf_clr     = (state == S_IDLE) && req;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = REG_OUT;
    rf_wdata = '0;
    if (state == S_EXEC) begin
      case (op)
        OP_MOV: begin rf_we = 1'b1; rf_waddr = fb; rf_wdata = ra; end
        OP_ADD: begin rf_we = 1'b1; rf_wdata = ra + rb; end
        OP_XOR: begin rf_we = 1'b1; rf_wdata = ra ^ rb; end
        OP_LDI: begin rf_we = 1'b1; rf_wdata = imm; end
        default: ;
      endcase
    end else if (state == S_LOAD) begin
      rf_we    = 1'b1;
      rf_wdata = dmem_rdata;
    end
  end

  mc_core_regfile #(.W(W)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rf_clr),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (fa),
    .raddr_b (fb),
    .rdata_a (ra),
    .rdata_b (rb),
    .out_reg (r7)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (req) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          ir <= imem_data;
          if (op == OP_HALT) begin
            state <= S_DONE;
          end else if (op == OP_LD) begin
            state <= S_LOAD;
          end else begin
            pc    <= pc_next;
            state <= end_hit ? S_DONE : S_FETCH;
          end
        end
        S_LOAD: begin
          pc    <= pc_next;
          state <= end_hit ? S_DONE : S_FETCH;
        end
        S_DONE: begin
          if (!req) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MC_CORE_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
    end else if (rf_clr) begin
      cycle_cnt <= '0;
    end else if ((state == S_FETCH || state == S_EXEC || state == S_LOAD) &&
                 cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_core
// Purpose  : Directed self-checking bench for mc_core with a store scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mc_core;

  localparam logic [2:0] MOV = 3'd0, ADD = 3'd1, XOR = 3'd2, LD = 3'd4,
                         ST = 3'd5, BEQ = 3'd6, HLT = 3'd7;

  logic        clk = 1'b0;
  logic        reset_n, req, req4;
  logic        done, done4;
  logic [11:0] imem_addr, imem_addr4;
  logic [8:0]  imem_data;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_addr4, dmem_wdata4;
  logic        dmem_we, dmem_we4;
`ifdef MC_CORE_CYCLE_CNT_EN
  logic [31:0] cycle_cnt, cycle_cnt4;
`endif

  int          checks = 0;
  int          errors = 0;
  int          wp;
  int          n;
  logic [15:0] sb [$];
  logic [15:0] exp_st;
  logic [8:0]  rom [0:4095];
  logic [7:0]  ram [0:255];
  logic        idle_bad, we4_seen;

  always #5 clk = ~clk;

  mc_core dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata)
`ifdef MC_CORE_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  mc_core #(.END_PC(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .req(req4), .done(done4),
    .imem_addr(imem_addr4), .imem_data(9'd0),
    .dmem_addr(dmem_addr4), .dmem_wdata(dmem_wdata4), .dmem_we(dmem_we4),
    .dmem_rdata(8'd0)
`ifdef MC_CORE_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt4)
`endif
  );

  always @(posedge clk) begin
    imem_data  <= rom[imem_addr];
    dmem_rdata <= ram[dmem_addr];
    if (dmem_we) ram[dmem_addr] <= dmem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every store strobe must match the next expected (addr,data) pair.
  always @(negedge clk) begin
    if (reset_n && dmem_we) begin
      check("store expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_st = sb.pop_front();
        check("store addr/data", {16'd0, dmem_addr, dmem_wdata}, {16'd0, exp_st});
      end
    end
    if (dmem_we4) we4_seen = 1'b1;
  end

  function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] b, input logic [2:0] a);
    return {op, b, a};
  endfunction

  function automatic logic [8:0] ldi(input logic [5:0] imm);
    return {3'b011, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 9'h1C0;
    wp = 0;
  endtask

  task automatic put(input logic [8:0] x);
    rom[wp] = x;
    wp++;
  endtask

  task automatic run(input string tag, input int exp_edges);
    int k;
    k = 0;
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    while (done !== 1'b1 && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check(tag, k, exp_edges);
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; req4 = 1'b0;
    idle_bad = 1'b0; we4_seen = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    clear_rom();

    repeat (3) @(negedge clk);
    check("reset done", done, 0);
    check("reset imem_addr", imem_addr, 0);
    check("reset dmem_we", dmem_we, 0);
    check("reset r7", dut.u_regfile.out_reg, 0);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || imem_addr !== 12'd0 || dmem_we !== 1'b0) idle_bad = 1'b1;
    end
    check("idle quiet", idle_bad, 0);

    // ALU chain: 4 instructions, done after edge 9.
    clear_rom();
    put(ldi(6'h3F)); put(ins(MOV, 1, 7)); put(ins(ADD, 1, 1)); put(ins(HLT, 0, 0));
    run("alu done edge", 9);
    check("alu r7", dut.u_regfile.out_reg, 8'h7E);
    check("alu halt pc", imem_addr, 3);
`ifdef MC_CORE_CYCLE_CNT_EN
    check("alu cycle_cnt", cycle_cnt, 8);
`endif

    // Reset during EXEC of a store aborts it.
    clear_rom();
    put(ldi(6'd5)); put(ins(MOV, 1, 7)); put(ins(ST, 7, 1)); put(ins(HLT, 0, 0));
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    n = 0;
    while (imem_addr !== 12'd2 && n < 20) begin @(negedge clk); n++; end
    check("st reach pc", imem_addr, 2);
    @(posedge clk); #1; reset_n = 1'b0;
    #1;
    check("abort dmem_we", dmem_we, 0);
    check("abort pc", imem_addr, 0);
    check("abort done", done, 0);
    for (int i = 0; i < 8; i++) check("abort reg", dut.u_regfile.regs[i], 0);
    @(posedge clk); #1;
    check("abort no store", ram[5], 0);
    @(negedge clk); reset_n = 1'b1;
    sb.push_back({8'd5, 8'd5});
    run("restart done edge", 9);
    check("restart store", ram[5], 8'd5);

    // XOR then store r7 to address r0.
    clear_rom();
    put(ldi(6'h2A)); put(ins(MOV, 1, 7)); put(ldi(6'h0F)); put(ins(XOR, 1, 7));
    put(ins(ST, 7, 0)); put(ins(HLT, 0, 0));
    sb.push_back({8'd0, 8'h25});
    run("xor done edge", 13);
    check("xor mem", ram[0], 8'h25);

    // Load/store round trip; the LD adds one cycle.
    clear_rom();
    put(ldi(6'h21)); put(ins(MOV, 2, 7)); put(ins(ADD, 2, 2)); put(ins(MOV, 2, 7));
    put(ins(ADD, 2, 2)); put(ins(MOV, 2, 7)); put(ldi(6'h21)); put(ins(ADD, 2, 7));
    put(ins(MOV, 2, 7)); put(ldi(6'd5)); put(ins(MOV, 1, 7)); put(ins(ST, 2, 1));
    put(ldi(6'd0)); put(ins(LD, 0, 1)); put(ins(HLT, 0, 0));
    sb.push_back({8'd5, 8'hA5});
    run("ldst done edge", 32);
    check("ldst r7", dut.u_regfile.out_reg, 8'hA5);
    check("ldst mem", ram[5], 8'hA5);
`ifdef MC_CORE_CYCLE_CNT_EN
    check("ldst cycle_cnt", cycle_cnt, 31);
`endif

    // Branch: r7 = 0xFE, BEQ at pc 10.
    clear_rom();
    put(ldi(6'h3F)); put(ins(MOV, 1, 7)); put(ins(ADD, 1, 1)); put(ins(MOV, 2, 7));
    put(ldi(6'd1)); put(ins(ADD, 7, 2)); put(ins(MOV, 2, 7)); put(ins(ADD, 2, 2));
    put(ins(MOV, 1, 0)); put(ins(MOV, 0, 0)); put(ins(BEQ, 1, 0)); put(ins(HLT, 0, 0));
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    n = 0;
    while (imem_addr !== 12'd10 && n < 60) begin @(negedge clk); n++; end
    check("beq reach pc", imem_addr, 10);
    n = 0;
    while (imem_addr === 12'd10 && n < 10) begin @(negedge clk); n++; end
    check("beq taken target", imem_addr, 8);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    rom[8] = ins(MOV, 1, 7);
    run("beq not-taken done edge", 25);
    check("beq not-taken pc", imem_addr, 11);

    // END_PC=4 with NOP stream; held req keeps DONE.
    @(negedge clk); req4 = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (done4 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check("endpc done edge", n, 9);
    repeat (5) @(negedge clk);
    check("endpc held done", done4, 1);
    @(negedge clk); req4 = 1'b0;
    @(posedge clk); #1;
    check("endpc done after drop", done4, 1);
    @(posedge clk); #1;
    check("endpc done cleared", done4, 0);
    check("endpc no store", we4_seen, 0);

    check("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
